// File: rtl/matmul_pkg.sv
// Shared types and helpers for the matmul engine: FSM state encoding,
// accumulator sizing and the incremental address-pointer step.
package matmul_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD_A = 3'd1,
    RD_B = 3'd2,
    MAC  = 3'd3,
    WR_C = 3'd4,
    DONE = 3'd5
  } state_t;

  localparam int PTR_W = 32;

  // Wide enough for a full dot product of 2^dim_w-1 maximal products.
  function automatic int acc_width(input int data_w, input int dim_w);
    return 2 * data_w + dim_w;
  endfunction

  function automatic logic [PTR_W-1:0] ptr_step(input logic [PTR_W-1:0] ptr,
                                                 input logic [PTR_W-1:0] inc);
    return ptr + inc;
  endfunction

endpackage

// File: rtl/matmul_if.sv
// Word-memory bus shared by the engine (master) and the memory (slave).
// A transfer completes in any cycle where mem_req and mem_ack are both high;
// addr/we/wdata hold while mem_req is high without ack; rdata is valid in the ack cycle.
interface matmul_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8,
  parameter int OUT_W  = 16
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [OUT_W-1:0]  mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/matmul_mac.sv
// Operand registers, multiplier and accumulator, plus the OUT_W
// clamp/truncate of the accumulated dot product with overflow detect.
module matmul_mac
  import matmul_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int OUT_W    = 16,
  parameter int DIM_W    = 8,
  parameter int SATURATE = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear_i,
  input  logic              load_a_i,
  input  logic              load_b_i,
  input  logic              mac_i,
  input  logic [DATA_W-1:0] rdata_i,
  output logic [OUT_W-1:0]  result_o,
  output logic              ovf_o
);
  localparam int ACC_W = acc_width(DATA_W, DIM_W);

  logic [DATA_W-1:0]   a_q, a_d, b_q, b_d;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic [2*DATA_W-1:0] prod;

  assign prod = a_q * b_q;

  always_comb begin
    a_d   = a_q;
    b_d   = b_q;
    acc_d = acc_q;
    if (load_a_i) a_d = rdata_i;
    if (load_b_i) b_d = rdata_i;
    if (clear_i)    acc_d = '0;
    else if (mac_i) acc_d = acc_q + ACC_W'(prod);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
    end else begin
      a_q   <= a_d;
      b_q   <= b_d;
      acc_q <= acc_d;
    end
  end

  // Any bit above OUT_W means the value does not fit the stored C element.
  assign ovf_o = (acc_q >> OUT_W) != '0;

  generate
    if (SATURATE != 0) begin : g_sat
      assign result_o = ovf_o ? '1 : OUT_W'(acc_q);
    end else begin : g_wrap
      assign result_o = OUT_W'(acc_q);
    end
  endgenerate

endmodule

// File: rtl/matmul_core.sv
// Self-sequencing C = A x B engine: FSM, loop counters and incremental
// address pointers driving a shared word memory over matmul_if.
module matmul_core
  import matmul_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int OUT_W    = 16,
  parameter int ADDR_W   = 16,
  parameter int DIM_W    = 8,
  parameter int SATURATE = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DIM_W-1:0]  dim_m,
  input  logic [DIM_W-1:0]  dim_k,
  input  logic [DIM_W-1:0]  dim_n,
  input  logic [ADDR_W-1:0] base_a,
  input  logic [ADDR_W-1:0] base_b,
  input  logic [ADDR_W-1:0] base_c,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  output state_t            dbg_state_o,
  matmul_if.master          mem
);

  state_t            state_q, state_d;
  logic [DIM_W-1:0]  dm_q, dm_d, dk_q, dk_d, dn_q, dn_d;
  logic [DIM_W-1:0]  i_q, i_d, j_q, j_d, k_q, k_d;
  logic [ADDR_W-1:0] a_row_q, a_row_d, a_ptr_q, a_ptr_d;
  logic [ADDR_W-1:0] b_col_q, b_col_d, b_ptr_q, b_ptr_d;
  logic [ADDR_W-1:0] c_ptr_q, c_ptr_d, base_b_q, base_b_d;
  logic              ovf_q, ovf_d;

  logic              mac_clear, mac_load_a, mac_load_b, mac_en, mac_ovf;
  logic [OUT_W-1:0]  mac_result;
  logic [ADDR_W-1:0] stride_k, stride_n, a_row_next, b_col_next;

  function automatic logic [ADDR_W-1:0] step(input logic [ADDR_W-1:0] p,
                                             input logic [ADDR_W-1:0] inc);
    return ADDR_W'(ptr_step(PTR_W'(p), PTR_W'(inc)));
  endfunction

  assign stride_k   = ADDR_W'(dk_q);
  assign stride_n   = ADDR_W'(dn_q);
  assign a_row_next = step(a_row_q, stride_k);
  assign b_col_next = step(b_col_q, ADDR_W'(1));

  matmul_mac #(
    .DATA_W  (DATA_W),
    .OUT_W   (OUT_W),
    .DIM_W   (DIM_W),
    .SATURATE(SATURATE)
  ) u_mac (
    .clk     (clk),
    .rst     (rst),
    .clear_i (mac_clear),
    .load_a_i(mac_load_a),
    .load_b_i(mac_load_b),
    .mac_i   (mac_en),
    .rdata_i (mem.mem_rdata),
    .result_o(mac_result),
    .ovf_o   (mac_ovf)
  );

  always_comb begin
    state_d  = state_q;
    dm_d     = dm_q;
    dk_d     = dk_q;
    dn_d     = dn_q;
    i_d      = i_q;
    j_d      = j_q;
    k_d      = k_q;
    a_row_d  = a_row_q;
    a_ptr_d  = a_ptr_q;
    b_col_d  = b_col_q;
    b_ptr_d  = b_ptr_q;
    c_ptr_d  = c_ptr_q;
    base_b_d = base_b_q;
    ovf_d    = ovf_q;
    mac_clear  = 1'b0;
    mac_load_a = 1'b0;
    mac_load_b = 1'b0;
    mac_en     = 1'b0;
    mem.mem_req   = 1'b0;
    mem.mem_we    = 1'b0;
    mem.mem_addr  = '0;
    mem.mem_wdata = '0;

    case (state_q)
      IDLE: begin
        if (start) begin
          dm_d     = dim_m;
          dk_d     = dim_k;
          dn_d     = dim_n;
          base_b_d = base_b;
          ovf_d    = 1'b0;
          i_d      = '0;
          j_d      = '0;
          k_d      = '0;
          a_row_d  = base_a;
          a_ptr_d  = base_a;
          b_col_d  = base_b;
          b_ptr_d  = base_b;
          c_ptr_d  = base_c;
          mac_clear = 1'b1;
          if (dim_m == '0 || dim_k == '0 || dim_n == '0) state_d = DONE;
          else                                           state_d = RD_A;
        end
      end
      RD_A: begin
        mem.mem_req  = 1'b1;
        mem.mem_addr = a_ptr_q;
        if (mem.mem_ack) begin
          mac_load_a = 1'b1;
          a_ptr_d    = step(a_ptr_q, ADDR_W'(1));
          state_d    = RD_B;
        end
      end
      RD_B: begin
        mem.mem_req  = 1'b1;
        mem.mem_addr = b_ptr_q;
        if (mem.mem_ack) begin
          mac_load_b = 1'b1;
          b_ptr_d    = step(b_ptr_q, stride_n);
          state_d    = MAC;
        end
      end
      MAC: begin
        mac_en = 1'b1;
        if (k_q == dk_q - DIM_W'(1)) begin
          state_d = WR_C;
        end else begin
          k_d     = k_q + DIM_W'(1);
          state_d = RD_A;
        end
      end
      WR_C: begin
        mem.mem_req   = 1'b1;
        mem.mem_we    = 1'b1;
        mem.mem_addr  = c_ptr_q;
        mem.mem_wdata = mac_result;
        if (mac_ovf) ovf_d = 1'b1;
        if (mem.mem_ack) begin
          mac_clear = 1'b1;
          k_d       = '0;
          c_ptr_d   = step(c_ptr_q, ADDR_W'(1));
          // End of a C row: next A row, B pointers back to column 0.
          if (j_q == dn_q - DIM_W'(1)) begin
            j_d     = '0;
            i_d     = i_q + DIM_W'(1);
            a_row_d = a_row_next;
            a_ptr_d = a_row_next;
            b_col_d = base_b_q;
            b_ptr_d = base_b_q;
            state_d = (i_q == dm_q - DIM_W'(1)) ? DONE : RD_A;
          end else begin
            j_d     = j_q + DIM_W'(1);
            a_ptr_d = a_row_q;
            b_col_d = b_col_next;
            b_ptr_d = b_col_next;
            state_d = RD_A;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      dm_q     <= '0;
      dk_q     <= '0;
      dn_q     <= '0;
      i_q      <= '0;
      j_q      <= '0;
      k_q      <= '0;
      a_row_q  <= '0;
      a_ptr_q  <= '0;
      b_col_q  <= '0;
      b_ptr_q  <= '0;
      c_ptr_q  <= '0;
      base_b_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      dm_q     <= dm_d;
      dk_q     <= dk_d;
      dn_q     <= dn_d;
      i_q      <= i_d;
      j_q      <= j_d;
      k_q      <= k_d;
      a_row_q  <= a_row_d;
      a_ptr_q  <= a_ptr_d;
      b_col_q  <= b_col_d;
      b_ptr_q  <= b_ptr_d;
      c_ptr_q  <= c_ptr_d;
      base_b_q <= base_b_d;
      ovf_q    <= ovf_d;
    end
  end

  assign busy        = (state_q != IDLE);
  assign done        = (state_q == DONE);
  assign overflow    = ovf_q;
  assign dbg_state_o = state_q;

endmodule
